// File: rtl/h_pc_ctrl_if.sv
// h_pc_ctrl_if: control/status bundle between the Hack decode/ALU side and the PC stage.
interface h_pc_ctrl_if #(parameter int WIDTH = 16);
   logic             reset;
   logic             stall;
   logic             is_c_inst;
   logic [2:0]       jbits;
   logic             zr;
   logic             ng;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] pc;
   logic             jumped;
   logic             halted;
   modport master (output reset, stall, is_c_inst, jbits, zr, ng, a_reg,
                   input  pc, jumped, halted);
   modport slave  (input  reset, stall, is_c_inst, jbits, zr, ng, a_reg,
                   output pc, jumped, halted);
endinterface

// File: rtl/h_pc_ctrl.sv
// h_pc_ctrl: Hack program counter with jump evaluation; PC_HALT_DETECT_EN adds jump-to-self halt.
module h_pc_ctrl #(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
   input  logic       clk,
   input  logic       rst_n,
   h_pc_ctrl_if.slave bus
);
   logic [WIDTH-1:0] r_pc;
   logic             r_jumped;
   logic             r_halted;
   logic             w_taken;
   logic             w_freeze;
   logic             w_self;
   assign w_taken = bus.is_c_inst & ((bus.jbits[2] & bus.ng) | (bus.jbits[1] & bus.zr) |
                                     (bus.jbits[0] & ~bus.ng & ~bus.zr));
`ifdef PC_HALT_DETECT_EN
   assign w_freeze = r_halted;
   assign w_self   = w_taken & (bus.a_reg == r_pc);
`else
   assign w_freeze = 1'b0;
   assign w_self   = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc     <= RESET_VEC;
         r_jumped <= 1'b0;
         r_halted <= 1'b0;
      end else if (bus.reset) begin
         r_pc     <= RESET_VEC;
         r_jumped <= 1'b0;
         r_halted <= 1'b0;
      end else if (!bus.stall && !w_freeze) begin
         r_pc     <= w_taken ? bus.a_reg : r_pc + WIDTH'(1);
         r_jumped <= w_taken;
         r_halted <= w_self;
      end
   end
   assign bus.pc     = r_pc;
   assign bus.jumped = r_jumped;
   assign bus.halted = r_halted;
endmodule
